// File: rtl/exec_pipe3.sv
`default_nettype none
// ============================================================================
// Module      : exec_pipe3
// Description : Three-stage integer execute pipeline fed by the reservation
//               station. S1 captures and decodes the issued uop, S2 computes,
//               S3 holds the result and drives the result-update bus.
//               Optional feature macro: EXEC_MUL_EN (class 011 multiply,
//               split across S2/S3 so latency stays at three cycles).
// Ports       : clk, CFI_PC_rst_n (async, active low)
//               DFI_PC_valid/uops/rs/rt/imm/rd/pc  issue slot
//               CFI_PC_stall (hold all stages), CFI_PC_clear (flush)
//               CFO_PC_ready, CFO_PC_busy, CFO_PC_illegal  status
//               CDO_PV/PA/PD_upt1  result bus (valid, dest reg, data)
// Revision    : 1.0  initial release
// ============================================================================
module exec_pipe3 #(
   parameter int W_PD_UOPS  = 6,
   parameter int W_PD_DATA  = 32,
   parameter int W_PA_REG   = 5,
   parameter int W_AA_INSTR = 32
) (
   input  logic                  clk,
   input  logic                  CFI_PC_rst_n,
   input  logic                  DFI_PC_valid,
   input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
   input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
   input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
   input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
   input  logic [W_PA_REG-1:0]   DFI_PA_rd,
   input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
   input  logic                  CFI_PC_stall,
   input  logic                  CFI_PC_clear,
   output logic                  CFO_PC_ready,
   output logic                  CDO_PV_upt1,
   output logic [W_PA_REG-1:0]   CDO_PA_upt1,
   output logic [W_PD_DATA-1:0]  CDO_PD_upt1,
   output logic                  CFO_PC_busy,
   output logic                  CFO_PC_illegal
);

   localparam logic [W_PD_UOPS-1:0] c_unused_op = '1;
   localparam logic [2:0] c_cls_rr  = 3'b000;
   localparam logic [2:0] c_cls_ri  = 3'b001;
   localparam logic [2:0] c_cls_pc  = 3'b010;
`ifdef EXEC_MUL_EN
   localparam logic [2:0] c_cls_mul = 3'b011;
   localparam int         c_half    = W_PD_DATA / 2;
`endif

   // ---------------- issue decode ----------------
   logic [2:0]           w_cls, w_fn, w_func;
   logic                 w_legal, w_issue;
   logic [W_PD_DATA-1:0] w_op_a, w_op_b;
`ifdef EXEC_MUL_EN
   logic                 w_is_mul;
`endif

   assign w_cls = DFI_PD_uops[W_PD_UOPS-1:W_PD_UOPS-3];
   assign w_fn  = DFI_PD_uops[2:0];

   always_comb begin
      w_legal = 1'b0;
      w_op_a  = DFI_PD_rs;
      w_op_b  = DFI_PD_rt;
      w_func  = w_fn;
`ifdef EXEC_MUL_EN
      w_is_mul = 1'b0;
`endif
      case (w_cls)
         c_cls_rr: w_legal = 1'b1;
         c_cls_ri: begin
            w_legal = 1'b1;
            w_op_b  = DFI_PD_imm;
         end
         c_cls_pc: begin
            // pc+imm reuses the adder: func forced to add
            w_legal = (w_fn == 3'd0);
            w_op_a  = DFI_AA_pc;
            w_op_b  = DFI_PD_imm;
            w_func  = 3'd0;
         end
`ifdef EXEC_MUL_EN
         c_cls_mul: begin
            w_legal  = (w_fn[2:1] == 2'b00);
            w_is_mul = 1'b1;
         end
`endif
         default: w_legal = 1'b0;
      endcase
   end

   assign CFO_PC_ready = !CFI_PC_stall && !CFI_PC_clear;
   // the all-ones uop is a bubble and never counts as work
   assign w_issue = DFI_PC_valid && CFO_PC_ready && (DFI_PD_uops != c_unused_op);

   // ---------------- S1: capture ----------------
   logic                 r_s1_valid, r_illegal;
   logic [2:0]           r_s1_func;
   logic [W_PD_DATA-1:0] r_s1_a, r_s1_b;
   logic [W_PA_REG-1:0]  r_s1_rd;
`ifdef EXEC_MUL_EN
   logic                 r_s1_mul;
`endif

   always_ff @(posedge clk or negedge CFI_PC_rst_n) begin
      if (!CFI_PC_rst_n) begin
         r_s1_valid <= 1'b0;
         r_illegal  <= 1'b0;
         r_s1_func  <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_rd    <= '0;
`ifdef EXEC_MUL_EN
         r_s1_mul   <= 1'b0;
`endif
      end else if (CFI_PC_clear) begin
         r_s1_valid <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (CFI_PC_stall) begin
         r_illegal  <= 1'b0;
      end else begin
         r_s1_valid <= w_issue && w_legal;
         r_illegal  <= w_issue && !w_legal;
         if (w_issue) begin
            r_s1_func <= w_func;
            r_s1_a    <= w_op_a;
            r_s1_b    <= w_op_b;
            r_s1_rd   <= DFI_PA_rd;
`ifdef EXEC_MUL_EN
            r_s1_mul  <= w_is_mul;
`endif
         end
      end
   end

   // ---------------- S1 -> S2: ALU ----------------
   logic [W_PD_DATA-1:0] w_alu;
   always_comb begin
      w_alu = '0;
      case (r_s1_func)
         3'd0:    w_alu = r_s1_a + r_s1_b;
         3'd1:    w_alu = r_s1_a - r_s1_b;
         3'd2:    w_alu = r_s1_a & r_s1_b;
         3'd3:    w_alu = r_s1_a | r_s1_b;
         3'd4:    w_alu = r_s1_a ^ r_s1_b;
         3'd5:    w_alu = {{(W_PD_DATA-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
         3'd6:    w_alu = r_s1_a << r_s1_b[4:0];
         default: w_alu = r_s1_a >> r_s1_b[4:0];
      endcase
   end

`ifdef EXEC_MUL_EN
   // Signed multiply as two partial products: a = a_hi*2^H + a_lo, with a_lo
   // unsigned and a_hi signed. S2 holds the partials, S3 combines them.
   logic signed [2*W_PD_DATA-1:0] w_ma_lo, w_ma_hi, w_mb, w_pp_lo, w_pp_hi;
   assign w_ma_lo = {{(2*W_PD_DATA-c_half){1'b0}}, r_s1_a[c_half-1:0]};
   assign w_ma_hi = {{(2*W_PD_DATA-c_half){r_s1_a[W_PD_DATA-1]}}, r_s1_a[W_PD_DATA-1:c_half]};
   assign w_mb    = {{W_PD_DATA{r_s1_b[W_PD_DATA-1]}}, r_s1_b};
   assign w_pp_lo = w_ma_lo * w_mb;
   assign w_pp_hi = w_ma_hi * w_mb;
`endif

   // ---------------- S2: compute ----------------
   logic                 r_s2_valid;
   logic [W_PA_REG-1:0]  r_s2_rd;
   logic [W_PD_DATA-1:0] r_s2_res;
`ifdef EXEC_MUL_EN
   logic                          r_s2_mul, r_s2_mul_hi;
   logic signed [2*W_PD_DATA-1:0] r_s2_pp_lo, r_s2_pp_hi;
`endif

   always_ff @(posedge clk or negedge CFI_PC_rst_n) begin
      if (!CFI_PC_rst_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_rd     <= '0;
         r_s2_res    <= '0;
`ifdef EXEC_MUL_EN
         r_s2_mul    <= 1'b0;
         r_s2_mul_hi <= 1'b0;
         r_s2_pp_lo  <= '0;
         r_s2_pp_hi  <= '0;
`endif
      end else if (CFI_PC_clear) begin
         r_s2_valid <= 1'b0;
      end else if (!CFI_PC_stall) begin
         r_s2_valid  <= r_s1_valid;
         r_s2_rd     <= r_s1_rd;
         r_s2_res    <= w_alu;
`ifdef EXEC_MUL_EN
         r_s2_mul    <= r_s1_mul;
         r_s2_mul_hi <= r_s1_func[0];
         r_s2_pp_lo  <= w_pp_lo;
         r_s2_pp_hi  <= w_pp_hi;
`endif
      end
   end

   // ---------------- S2 -> S3: result select ----------------
   logic [W_PD_DATA-1:0] w_s3_next;
`ifdef EXEC_MUL_EN
   logic signed [2*W_PD_DATA-1:0] w_prod;
   assign w_prod = (r_s2_pp_hi <<< c_half) + r_s2_pp_lo;
   always_comb begin
      w_s3_next = r_s2_res;
      if (r_s2_mul)
         w_s3_next = r_s2_mul_hi ? w_prod[2*W_PD_DATA-1:W_PD_DATA] : w_prod[W_PD_DATA-1:0];
   end
`else
   assign w_s3_next = r_s2_res;
`endif

   // ---------------- S3: result register ----------------
   logic                 r_s3_valid;
   logic [W_PA_REG-1:0]  r_s3_rd;
   logic [W_PD_DATA-1:0] r_s3_data;

   always_ff @(posedge clk or negedge CFI_PC_rst_n) begin
      if (!CFI_PC_rst_n) begin
         r_s3_valid <= 1'b0;
         r_s3_rd    <= '0;
         r_s3_data  <= '0;
      end else if (CFI_PC_clear) begin
         r_s3_valid <= 1'b0;
      end else if (!CFI_PC_stall) begin
         r_s3_valid <= r_s2_valid;
         r_s3_rd    <= r_s2_rd;
         r_s3_data  <= w_s3_next;
      end
   end

   // r0 results occupy the pipe but are never broadcast
   assign CDO_PV_upt1    = r_s3_valid && (r_s3_rd != '0);
   assign CDO_PA_upt1    = r_s3_rd;
   assign CDO_PD_upt1    = r_s3_data;
   assign CFO_PC_busy    = r_s1_valid || r_s2_valid || r_s3_valid;
   assign CFO_PC_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_exec_pipe3.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_pipe3
// Description : Directed self-checking bench for exec_pipe3. Expected values
//               are hand-computed constants. Honours EXEC_MUL_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_exec_pipe3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, stall, clear;
   logic [5:0]  uops;
   logic [31:0] rs, rt, imm, pc;
   logic [4:0]  rd;
   logic        ready, pv, busy, illegal;
   logic [4:0]  pa;
   logic [31:0] pd;

   int total = 0;
   int bad   = 0;

   exec_pipe3 dut (
      .clk            (clk),
      .CFI_PC_rst_n   (rst_n),
      .DFI_PC_valid   (valid),
      .DFI_PD_uops    (uops),
      .DFI_PD_rs      (rs),
      .DFI_PD_rt      (rt),
      .DFI_PD_imm     (imm),
      .DFI_PA_rd      (rd),
      .DFI_AA_pc      (pc),
      .CFI_PC_stall   (stall),
      .CFI_PC_clear   (clear),
      .CFO_PC_ready   (ready),
      .CDO_PV_upt1    (pv),
      .CDO_PA_upt1    (pa),
      .CDO_PD_upt1    (pd),
      .CFO_PC_busy    (busy),
      .CFO_PC_illegal (illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p, input logic [4:0] d);
      valid = 1'b1;
      uops  = u;
      rs    = a;
      rt    = b;
      imm   = im;
      pc    = p;
      rd    = d;
   endtask

   task automatic idle();
      valid = 1'b0;
      uops  = 6'h00;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      clear = 1'b0;
      idle();
      rs = '0; rt = '0; imm = '0; pc = '0; rd = '0;
      step();
      step();
      // reset state
      chk("rst_pv", {31'd0, pv}, 32'd0);
      chk("rst_pa", {27'd0, pa}, 32'd0);
      chk("rst_pd", pd, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // T2: add wraps to zero, result three cycles after issue
      drive(6'o00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
      step();
      idle();
      step();
      chk("t2_early_pv", {31'd0, pv}, 32'd0);
      step();
      chk("t2_pv", {31'd0, pv}, 32'd1);
      chk("t2_pa", {27'd0, pa}, 32'd3);
      chk("t2_pd", pd, 32'd0);
      step();
      chk("t2_single_pv", {31'd0, pv}, 32'd0);

      // T3: back-to-back sub, slt, sll by 33, pc+imm
      drive(6'o01, 32'd10, 32'd3, 32'd0, 32'd0, 5'd1);
      step();
      drive(6'o05, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd2);
      step();
      drive(6'o06, 32'h4000_0003, 32'd33, 32'd0, 32'd0, 5'd4);
      step();
      chk("t3_sub_pv", {31'd0, pv}, 32'd1);
      chk("t3_sub_pd", pd, 32'd7);
      drive(6'o20, 32'd0, 32'd0, 32'd4, 32'h100, 5'd5);
      step();
      chk("t3_slt_pa", {27'd0, pa}, 32'd2);
      chk("t3_slt_pd", pd, 32'd1);
      idle();
      step();
      chk("t3_sll_pa", {27'd0, pa}, 32'd4);
      chk("t3_sll_pd", pd, 32'h8000_0006);
      step();
      chk("t3_pc_pv", {31'd0, pv}, 32'd1);
      chk("t3_pc_pa", {27'd0, pa}, 32'd5);
      chk("t3_pc_pd", pd, 32'h0000_0104);
      step();
      chk("t3_drain_pv", {31'd0, pv}, 32'd0);
      chk("t3_drain_busy", {31'd0, busy}, 32'd0);

      // T4: stall with S1..S3 full and a uop waiting at the input
      drive(6'o10, 32'd100, 32'd0, 32'd1, 32'd0, 5'd6);
      step();
      drive(6'o10, 32'd200, 32'd0, 32'd2, 32'd0, 5'd7);
      step();
      drive(6'o04, 32'hF0, 32'hFF, 32'd0, 32'd0, 5'd8);
      step();
      chk("t4_a_pd", pd, 32'd101);
      drive(6'o03, 32'd1, 32'd2, 32'd0, 32'd0, 5'd9);
      stall = 1'b1;
      #1;
      chk("t4_ready", {31'd0, ready}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t4_hold_pv", {31'd0, pv}, 32'd1);
         chk("t4_hold_pa", {27'd0, pa}, 32'd6);
         chk("t4_hold_pd", pd, 32'd101);
      end
      stall = 1'b0;
      step();
      idle();
      chk("t4_b_pa", {27'd0, pa}, 32'd7);
      chk("t4_b_pd", pd, 32'd202);
      step();
      chk("t4_c_pa", {27'd0, pa}, 32'd8);
      chk("t4_c_pd", pd, 32'h0F);
      step();
      chk("t4_d_pa", {27'd0, pa}, 32'd9);
      chk("t4_d_pd", pd, 32'd3);
      step();
      chk("t4_nodup_pv", {31'd0, pv}, 32'd0);

      // T5: clear together with stall and valid
      drive(6'o00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd10);
      step();
      drive(6'o00, 32'd2, 32'd2, 32'd0, 32'd0, 5'd11);
      clear = 1'b1;
      stall = 1'b1;
      #1;
      chk("t5_ready", {31'd0, ready}, 32'd0);
      step();
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_pv", {31'd0, pv}, 32'd0);
      clear = 1'b0;
      stall = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_noresult_pv", {31'd0, pv}, 32'd0);
      end

      // T6: multiply class
`ifdef EXEC_MUL_EN
      drive(6'o30, 32'd7, 32'd6, 32'd0, 32'd0, 5'd12);
      step();
      chk("t6_mul_noillegal", {31'd0, illegal}, 32'd0);
      chk("t6_mul_busy", {31'd0, busy}, 32'd1);
      idle();
      step();
      step();
      chk("t6_mul_pv", {31'd0, pv}, 32'd1);
      chk("t6_mul_pa", {27'd0, pa}, 32'd12);
      chk("t6_mul_pd", pd, 32'd42);
      drive(6'o31, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 5'd13);
      step();
      idle();
      step();
      step();
      chk("t6_mulh_pd", pd, 32'hFFFF_FFFF);
      step();
`else
      drive(6'o30, 32'd7, 32'd6, 32'd0, 32'd0, 5'd12);
      step();
      chk("t6_mul_illegal", {31'd0, illegal}, 32'd1);
      chk("t6_mul_busy", {31'd0, busy}, 32'd0);
      idle();
      step();
      chk("t6_mul_pulse_end", {31'd0, illegal}, 32'd0);
      step();
      step();
      chk("t6_mul_nores", {31'd0, pv}, 32'd0);
`endif

      // T6: rd=0 add flows through, busy set, never broadcast
      drive(6'o00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd0);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("t6_r0_busy", {31'd0, busy}, 32'd1);
         chk("t6_r0_pv", {31'd0, pv}, 32'd0);
         step();
      end
      chk("t6_r0_idle", {31'd0, busy}, 32'd0);

      // other illegal encodings and the bubble
      drive(6'o40, 32'd1, 32'd1, 32'd0, 32'd0, 5'd14);
      step();
      chk("ill_cls4", {31'd0, illegal}, 32'd1);
      drive(6'o21, 32'd1, 32'd1, 32'd0, 32'd0, 5'd14);
      step();
      chk("ill_pcfn1", {31'd0, illegal}, 32'd1);
      chk("ill_busy", {31'd0, busy}, 32'd0);
      drive(6'o77, 32'd1, 32'd1, 32'd0, 32'd0, 5'd14);
      step();
      chk("bubble_illegal", {31'd0, illegal}, 32'd0);
      chk("bubble_busy", {31'd0, busy}, 32'd0);
      idle();
      step();
      step();
      chk("bubble_pv", {31'd0, pv}, 32'd0);

      // T1: reset mid-stream, then restart
      drive(6'o00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1);
      step();
      drive(6'o00, 32'd3, 32'd4, 32'd0, 32'd0, 5'd2);
      step();
      drive(6'o00, 32'd5, 32'd6, 32'd0, 32'd0, 5'd3);
      step();
      chk("t1_pre_pd", pd, 32'd3);
      idle();
      rst_n = 1'b0;
      #2;
      chk("t1_pv", {31'd0, pv}, 32'd0);
      chk("t1_pa", {27'd0, pa}, 32'd0);
      chk("t1_pd", pd, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd0);
      step();
      rst_n = 1'b1;
      drive(6'o00, 32'd5, 32'd6, 32'd0, 32'd0, 5'd13);
      step();
      idle();
      step();
      step();
      chk("t1_after_pv", {31'd0, pv}, 32'd1);
      chk("t1_after_pa", {27'd0, pa}, 32'd13);
      chk("t1_after_pd", pd, 32'd11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
